// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN / INSTR_W : architectural address and instruction widths
//   fetch_state_t  : fetch FSM states (RUN fetches, FAULT is halted until reset)
//   fetch_entry_t  : one instruction-queue entry, the instruction word and its pc
package rv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small in-order queue of fetched instructions sitting between the fetch
// stage and decode.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : enqueue push_entry at the clock edge
//   pop         : dequeue the head at the clock edge
//   flush       : drop all entries at the clock edge (wins over push and pop)
//   push_entry  : entry to enqueue
//   head_entry  : current head entry (meaningful only while valid)
//   valid       : queue holds at least one entry
//   full        : queue holds DEPTH entries
module fetch_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic         valid,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign valid = (count != '0);
  assign full  = (count == (PW+1)'(DEPTH));

  // A push into a full queue is only legal when the head leaves in the same
  // cycle; flush discards everything, so nothing is written during a flush.
  assign pop_ok  = pop & valid & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  assign head_entry = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, fetches from instruction
// memory, queues fetched words and hands them to decode over valid/ready.
// Redirects from execute flush the queue; misaligned redirects and
// out-of-range fetches raise a sticky fault and halt fetching until reset.
//   clk, reset        : clock, asynchronous active-high reset
//   imem_addr         : byte address to instruction memory (the fetch pc register)
//   imem_rdata        : instruction word for imem_addr, same cycle
//   redirect_valid/pc : control-flow redirect request and target
//   out_valid/ready   : handshake towards decode
//   out_instr/pc      : head instruction and its pc
//   out_pc_plus4      : out_pc + 4
//   fault, fault_pc   : sticky fetch fault and the address that caused it
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          MEM_WORDS   = 512
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic         is_run;
  logic         in_range;
  logic         pop;
  logic         push;
  logic         redirect_take;
  logic         range_fault;
  logic         q_full;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign is_run        = (state == RUN);
  assign in_range      = ({2'b00, fetch_pc[31:2]} < MEM_WORDS_W);
  assign pop           = out_valid & out_ready;
  assign redirect_take = is_run & redirect_valid;
  // A redirect in the same cycle suppresses both fetching and the range check.
  assign push          = is_run & ~redirect_valid & in_range & (~q_full | pop);
  assign range_fault   = is_run & ~redirect_valid & ~in_range;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = fetch_pc;
  assign imem_addr        = fetch_pc;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_take),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .valid      (out_valid),
    .full       (q_full)
  );

  assign out_instr    = head_entry.instr;
  assign out_pc       = head_entry.pc;
  assign out_pc_plus4 = head_entry.pc + 32'd4;

  // Once in FAULT nothing here changes again until reset, which keeps
  // fault_pc pinned to the first offending address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_take) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        fetch_pc <= redirect_pc;
      end
    end else if (range_fault) begin
      state    <= FAULT;
      fault    <= 1'b1;
      fault_pc <= fetch_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // A misaligned reset vector is a build-time configuration mistake.
  assert property (@(posedge clk) RESET_PC[1:0] == 2'b00);

endmodule
